rename: RTL

- Rename/dispatch stage between decode and the reservation stations (RS).
- Allocates a ROB id per instruction, notifies the ROB, and issues source lookups plus a destination tag write to the register alias table.
- Resolves RAT results against writebacks the RAT cannot see, and hands fully tagged/valued operands to the RS through a stall handshake.
- Two stages: A (lookup/allocate, combinational on decode inputs) and B (one-entry resolve/hold register).

---
 rtl/rename.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/rename.sv
// Rename/dispatch stage: allocates ROB ids, drives RAT lookups and resolves operands for the RS.
// Optional x0 handling is enabled by defining RENAME_X0_EN.
module rename #(
  parameter int OPW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           decode_rename_valid,
  input  logic [OPW-1:0] decode_rename_op,
  input  logic [31:0]    decode_rename_imm,
  input  logic [5:0]     decode_rename_rd,
  input  logic [4:0]     decode_rename_rs1,
  input  logic [4:0]     decode_rename_rs2,
  output logic           rename_stall,
  output logic           rename_rat_valid,
  output logic [5:0]     rename_rat_rd,
  output logic [7:0]     rename_rat_robid,
  output logic [4:0]     rename_rat_rs1,
  output logic [4:0]     rename_rat_rs2,
  input  logic           rat_rs1_valid,
  input  logic [31:0]    rat_rs1_tagval,
  input  logic           rat_rs2_valid,
  input  logic [31:0]    rat_rs2_tagval,
  input  logic           rob_full,
  input  logic           rob_flush,
  output logic           rename_rob_valid,
  output logic [5:0]     rename_rob_rd,
  output logic [7:0]     rename_rob_robid,
  input  logic           wb_valid,
  input  logic           wb_error,
  input  logic [7:0]     wb_robid,
  input  logic [5:0]     wb_rd,
  input  logic [31:0]    wb_result,
  input  logic           rs_stall,
  output logic           rename_rs_valid,
  output logic [OPW-1:0] rename_rs_op,
  output logic [31:0]    rename_rs_imm,
  output logic [7:0]     rename_rs_robid,
  output logic [5:0]     rename_rs_rd,
  output logic           rename_rs_rs1_valid,
  output logic [31:0]    rename_rs_rs1_tagval,
  output logic           rename_rs_rs2_valid,
  output logic [31:0]    rename_rs_rs2_tagval
);

  logic [7:0]     robid_cnt;
  logic           b_valid;
  logic           b_fresh;
  logic [OPW-1:0] b_op;
  logic [31:0]    b_imm;
  logic [5:0]     b_rd;
  logic [7:0]     b_robid;
  logic           h1_valid;
  logic [31:0]    h1_tagval;
  logic           h2_valid;
  logic [31:0]    h2_tagval;
  logic           cwb_valid;
  logic [6:0]     cwb_robid;
  logic [31:0]    cwb_result;

  logic           fire;
  logic           live_ok;
  logic [5:0]     eff_rd;
  logic           src1_valid;
  logic [31:0]    src1_tagval;
  logic           src2_valid;
  logic [31:0]    src2_tagval;
  logic [32:0]    res1;
  logic [32:0]    res2;
  logic           unused_wb;

  assign unused_wb = &{1'b0, wb_rd[4:0], wb_robid[7]};

  assign rename_stall = rob_full | (b_valid & rs_stall);
  assign fire         = decode_rename_valid & ~rename_stall & ~rob_flush;
  assign live_ok      = wb_valid & ~wb_error & wb_rd[5];

`ifdef RENAME_X0_EN
  logic b_rs1_zero;
  logic b_rs2_zero;
  assign eff_rd = {decode_rename_rd[5] & (decode_rename_rd[4:0] != 5'd0), decode_rename_rd[4:0]};
`else
  assign eff_rd = decode_rename_rd;
`endif

  assign rename_rat_valid = fire;
  assign rename_rat_rd    = eff_rd;
  assign rename_rat_robid = robid_cnt;
  assign rename_rat_rs1   = decode_rename_rs1;
  assign rename_rat_rs2   = decode_rename_rs2;
  assign rename_rob_valid = fire;
  assign rename_rob_rd    = eff_rd;
  assign rename_rob_robid = robid_cnt;

  // Tags compare on [6:0]; the captured wb covers the lookup cycle the RAT could not see.
  function automatic logic [32:0] resolve(
    input logic        sv,
    input logic [31:0] st,
    input logic        cv,
    input logic [6:0]  cid,
    input logic [31:0] cres,
    input logic        lv,
    input logic [6:0]  lid,
    input logic [31:0] lres
  );
    if (sv)
      return {1'b1, st};
    else if (cv && (st[6:0] == cid))
      return {1'b1, cres};
    else if (lv && (st[6:0] == lid))
      return {1'b1, lres};
    else
      return {1'b0, 25'b0, st[6:0]};
  endfunction

  always_comb begin
    src1_valid  = b_fresh ? rat_rs1_valid  : h1_valid;
    src1_tagval = b_fresh ? rat_rs1_tagval : h1_tagval;
    src2_valid  = b_fresh ? rat_rs2_valid  : h2_valid;
    src2_tagval = b_fresh ? rat_rs2_tagval : h2_tagval;
    res1 = resolve(src1_valid, src1_tagval, cwb_valid, cwb_robid, cwb_result,
                   live_ok, wb_robid[6:0], wb_result);
    res2 = resolve(src2_valid, src2_tagval, cwb_valid, cwb_robid, cwb_result,
                   live_ok, wb_robid[6:0], wb_result);
`ifdef RENAME_X0_EN
    if (b_rs1_zero) res1 = {1'b1, 32'b0};
    if (b_rs2_zero) res2 = {1'b1, 32'b0};
`endif
  end

  assign rename_rs_valid      = b_valid;
  assign rename_rs_op         = b_op;
  assign rename_rs_imm        = b_imm;
  assign rename_rs_robid      = b_robid;
  assign rename_rs_rd         = b_rd;
  assign rename_rs_rs1_valid  = res1[32];
  assign rename_rs_rs1_tagval = res1[31:0];
  assign rename_rs_rs2_valid  = res2[32];
  assign rename_rs_rs2_tagval = res2[31:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      robid_cnt  <= 8'd0;
      b_valid    <= 1'b0;
      b_fresh    <= 1'b0;
      b_op       <= '0;
      b_imm      <= 32'd0;
      b_rd       <= 6'd0;
      b_robid    <= 8'd0;
      h1_valid   <= 1'b0;
      h1_tagval  <= 32'd0;
      h2_valid   <= 1'b0;
      h2_tagval  <= 32'd0;
      cwb_valid  <= 1'b0;
      cwb_robid  <= 7'd0;
      cwb_result <= 32'd0;
    end else begin
      if (rob_flush) begin
        b_valid   <= 1'b0;
        b_fresh   <= 1'b0;
        robid_cnt <= 8'd0;
      end else if (fire) begin
        b_valid    <= 1'b1;
        b_fresh    <= 1'b1;
        b_op       <= decode_rename_op;
        b_imm      <= decode_rename_imm;
        b_rd       <= eff_rd;
        b_robid    <= robid_cnt;
        robid_cnt  <= robid_cnt + 8'd1;
        cwb_valid  <= live_ok;
        cwb_robid  <= wb_robid[6:0];
        cwb_result <= wb_result;
      end else begin
        b_fresh <= 1'b0;
        if (b_valid && !rs_stall)
          b_valid <= 1'b0;
      end
      // Absorb writebacks that land while the RS is stalling us.
      if (b_valid && rs_stall) begin
        h1_valid  <= res1[32];
        h1_tagval <= res1[31:0];
        h2_valid  <= res2[32];
        h2_tagval <= res2[31:0];
      end
    end
  end

`ifdef RENAME_X0_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_rs1_zero <= 1'b0;
      b_rs2_zero <= 1'b0;
    end else if (fire && !rob_flush) begin
      b_rs1_zero <= (decode_rename_rs1 == 5'd0);
      b_rs2_zero <= (decode_rename_rs2 == 5'd0);
    end
  end
`endif

endmodule
